// File: rtl/serdes_pulse_gen_if.sv
// Control/data bundle between a pulse requester and serdes_pulse_gen.
// Master drives enable/trigger/delay/width; slave returns word, busy and reject flag.
interface serdes_pulse_gen_if #(
  parameter int DATA_WIDTH       = 4,
  parameter int DELAY_WIDTH      = 24,
  parameter int PULSE_WIDTH_BITS = 24
);
  logic                        enable;
  logic                        trigger;
  logic [DELAY_WIDTH-1:0]      delay;
  logic [PULSE_WIDTH_BITS-1:0] width;
  logic [DATA_WIDTH-1:0]       data_out;
  logic                        busy;
  logic                        trigger_ignored;

  modport master (
    output enable, trigger, delay, width,
    input  data_out, busy, trigger_ignored
  );

  modport slave (
    input  enable, trigger, delay, width,
    output data_out, busy, trigger_ignored
  );
endinterface

// File: rtl/serdes_pulse_gen.sv
// Fine-delay pulse generator on the serializer parallel clock.
// Emits one DATA_WIDTH-bit word per clock, bit 0 first, with UI-resolution edges.
module serdes_pulse_gen #(
  parameter int DATA_WIDTH       = 4,
  parameter int DELAY_WIDTH      = 24,
  parameter int PULSE_WIDTH_BITS = 24,
  parameter bit INVERT           = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  serdes_pulse_gen_if.slave pb
);

  localparam int LW = $clog2(DATA_WIDTH);
  localparam int MW = (DELAY_WIDTH > PULSE_WIDTH_BITS) ?
                      DELAY_WIDTH : PULSE_WIDTH_BITS;
  // Extra headroom so word base + DATA_WIDTH never wraps past end
  localparam int EW = MW + 2;
  localparam int CW = DELAY_WIDTH - LW;
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {DATA_WIDTH{INVERT}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_PULSE
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [EW-1:0]          ui_q, ui_d;
  logic [DELAY_WIDTH-1:0] dly_q, dly_d;
  logic [EW-1:0]          end_q, end_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   ign_q, ign_d;

  logic [DATA_WIDTH-1:0]  mask;
  logic [EW-1:0]          pos;
  logic                   last;

  always_comb begin
    mask = '0;
    pos  = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      pos     = ui_q + EW'(j);
      mask[j] = (pos >= EW'(dly_q)) && (pos < end_q);
    end
    last = (ui_q + EW'(DATA_WIDTH)) >= end_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ui_d    = ui_q;
    dly_d   = dly_q;
    end_d   = end_q;
    data_d  = IDLE_WORD;
    ign_d   = 1'b0;
    if (!pb.enable) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pb.trigger && (pb.width != '0)) begin
            dly_d   = pb.delay;
            end_d   = EW'(pb.delay) + EW'(pb.width);
            cnt_d   = CW'(pb.delay >> LW);
            ui_d    = EW'(pb.delay >> LW) << LW;
            state_d = (cnt_d != '0) ? S_DELAY : S_PULSE;
          end
        end
        S_DELAY: begin
          ign_d = pb.trigger;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = S_PULSE;
          end
        end
        S_PULSE: begin
          ign_d  = pb.trigger;
          data_d = mask ^ IDLE_WORD;
          ui_d   = ui_q + EW'(DATA_WIDTH);
          if (last) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ui_q    <= '0;
      dly_q   <= '0;
      end_q   <= '0;
      data_q  <= IDLE_WORD;
      busy_q  <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ui_q    <= ui_d;
      dly_q   <= dly_d;
      end_q   <= end_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      ign_q   <= ign_d;
    end
  end

  assign pb.data_out        = data_q;
  assign pb.busy            = busy_q;
  assign pb.trigger_ignored = ign_q;

endmodule

// File: tb/tb_serdes_pulse_gen.sv
// Bench for serdes_pulse_gen: three configurations share one stimulus stream
// and are checked against a UI-level pulse model.
module tb_serdes_pulse_gen;

  logic clk;
  logic reset;
  logic en;
  logic trg;
  logic [23:0] dl;
  logic [23:0] wd;

  serdes_pulse_gen_if #(.DATA_WIDTH(4)) if0 ();
  serdes_pulse_gen_if #(.DATA_WIDTH(4)) if1 ();
  serdes_pulse_gen_if #(.DATA_WIDTH(8)) if2 ();

  assign if0.enable  = en;
  assign if0.trigger = trg;
  assign if0.delay   = dl;
  assign if0.width   = wd;
  assign if1.enable  = en;
  assign if1.trigger = trg;
  assign if1.delay   = dl;
  assign if1.width   = wd;
  assign if2.enable  = en;
  assign if2.trigger = trg;
  assign if2.delay   = dl;
  assign if2.width   = wd;

  serdes_pulse_gen #(.DATA_WIDTH(4), .INVERT(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .pb(if0.slave)
  );
  serdes_pulse_gen #(.DATA_WIDTH(4), .INVERT(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .pb(if1.slave)
  );
  serdes_pulse_gen #(.DATA_WIDTH(8), .INVERT(1'b0)) u_dut2 (
    .clk(clk), .reset(reset), .pb(if2.slave)
  );

  logic [7:0] got_d [3];
  logic       got_b [3];
  logic       got_i [3];

  assign got_d[0] = {4'h0, if0.data_out};
  assign got_d[1] = {4'h0, if1.data_out};
  assign got_d[2] = if2.data_out;
  assign got_b[0] = if0.busy;
  assign got_b[1] = if1.busy;
  assign got_b[2] = if2.busy;
  assign got_i[0] = if0.trigger_ignored;
  assign got_i[1] = if1.trigger_ignored;
  assign got_i[2] = if2.trigger_ignored;

  int n_cmp = 0;
  int n_err = 0;

  int     mw   [3] = '{4, 4, 8};
  bit     minv [3] = '{1'b0, 1'b1, 1'b0};
  bit     m_act [3];
  longint m_t0  [3];
  longint m_d   [3];
  longint m_w   [3];
  logic [7:0] e_data [3];
  bit     e_busy [3];
  bit     e_ign  [3];
  longint cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Word k of a pulse covers UI k*W .. k*W+W-1
  function automatic logic [7:0] word_of(longint d, longint w, longint k,
                                         int wdt, bit inv);
    logic [7:0] r;
    longint ui;
    r = '0;
    for (int j = 0; j < wdt; j++) begin
      ui   = k * wdt + j;
      r[j] = ((ui >= d) && (ui < d + w)) ^ inv;
    end
    return r;
  endfunction

  function automatic longint nwords(longint d, longint w, int wdt);
    return (d + w - 1) / wdt + 1;
  endfunction

  task automatic mdl_edge();
    bit bb;
    for (int i = 0; i < 3; i++) begin
      if (!en) begin
        m_act[i]  = 1'b0;
        e_data[i] = word_of(0, 0, 0, mw[i], minv[i]);
        e_busy[i] = 1'b0;
        e_ign[i]  = 1'b0;
      end else begin
        bb        = m_act[i];
        e_ign[i]  = trg && bb;
        e_data[i] = bb ? word_of(m_d[i], m_w[i], cyc - m_t0[i] - 1,
                                 mw[i], minv[i])
                       : word_of(0, 0, 0, mw[i], minv[i]);
        if (bb) begin
          m_act[i] = (cyc - m_t0[i]) < nwords(m_d[i], m_w[i], mw[i]);
        end else if (trg && (wd != 0)) begin
          m_act[i] = 1'b1;
          m_t0[i]  = cyc;
          m_d[i]   = longint'(dl);
          m_w[i]   = longint'(wd);
        end
        e_busy[i] = m_act[i];
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("data%0d", i), 32'(got_d[i]), 32'(e_data[i]));
      chk($sformatf("busy%0d", i), 32'(got_b[i]), 32'(e_busy[i]));
      chk($sformatf("ign%0d", i),  32'(got_i[i]), 32'(e_ign[i]));
    end
  endtask

  task automatic step(bit e_, bit t_, int unsigned d_, int unsigned w_);
    en  = e_;
    trg = t_;
    dl  = 24'(d_);
    wd  = 24'(w_);
    @(posedge clk);
    cyc++;
    mdl_edge();
    #1;
    check_all();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, $urandom_range(0, 50), $urandom_range(0, 50));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en    = 1'b0;
    trg   = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      m_act[i]  = 1'b0;
      e_data[i] = word_of(0, 0, 0, mw[i], minv[i]);
      e_busy[i] = 1'b0;
      e_ign[i]  = 1'b0;
    end
    check_all();
    @(posedge clk);
    cyc++;
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b0;
    trg   = 1'b0;
    dl    = '0;
    wd    = '0;
    for (int i = 0; i < 3; i++) begin
      m_act[i] = 1'b0;
      m_t0[i]  = 0;
      m_d[i]   = 0;
      m_w[i]   = 0;
    end
    #2;
    do_reset();

    step(1'b1, 1'b1, 0, 4);
    idle(4);
    step(1'b1, 1'b1, 5, 6);
    idle(5);
    step(1'b1, 1'b1, 2, 1);
    idle(3);
    step(1'b1, 1'b1, 0, 0);
    idle(3);

    step(1'b1, 1'b1, 8, 100);
    idle(3);
    step(1'b1, 1'b1, 3, 3);
    idle(30);

    step(1'b1, 1'b1, 0, 4);
    step(1'b1, 1'b1, 0, 4);
    idle(3);

    step(1'b1, 1'b1, 1, 2);
    idle(3);
    step(1'b1, 1'b1, 13, 3);
    idle(4);

    step(1'b1, 1'b1, 0, 200);
    idle(10);
    step(1'b0, 1'b1, 0, 4);
    step(1'b0, 1'b0, 0, 4);
    idle(3);

    step(1'b1, 1'b1, 0, 200);
    idle(5);
    do_reset();
    idle(3);

    for (int n = 0; n < 400; n++) begin
      step(($urandom % 20) != 0,
           ($urandom % 4) == 0,
           $urandom_range(0, 30),
           (($urandom % 8) == 0) ? 0 : $urandom_range(1, 30));
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serdes_pulse_gen.md
Name: serdes_pulse_gen

Overview:
- Fine-delay pulse generator running in the parallel-side (clk_div) domain of the output SERDES.
- On a trigger strobe it produces one rectangular pulse with programmable delay and width, both in serial unit intervals (UI).
- Output is a DATA_WIDTH-bit word per clock, fed directly to the output serializer's parallel input. Bit 0 is transmitted first.

Parameters:
- DATA_WIDTH, 4, serializer ratio (UI per clock); legal values 2, 4, 8 only.
- DELAY_WIDTH, 24, width of delay input in UI.
- PULSE_WIDTH_BITS, 24, width of pulse-width input in UI.
- INVERT, 0, 1 = idle level high and pulse low; 0 = idle low and pulse high.

Ports:
- clk  input  1  parallel-side clock (same as serializer clk_div).
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  generator enable; low aborts any pulse.
- trigger  input  1  single-cycle start strobe.
- delay  input  DELAY_WIDTH  UI from the reference point to the pulse leading edge.
- width  input  PULSE_WIDTH_BITS  pulse length in UI; 0 = no pulse.
- data_out  output  DATA_WIDTH  parallel word to the serializer; bit 0 goes out first.
- busy  output  1  high while a pulse is scheduled or in progress.
- trigger_ignored  output  1  one-cycle flag: trigger was rejected.

Behaviour:
- Reset (async assert):
  - data_out = {DATA_WIDTH{INVERT}}.
  - busy = 0, trigger_ignored = 0, FSM = IDLE, all counters 0.
- Reference point: the trigger is sampled at edge n. Word k (k = 0, 1, ...) is driven on data_out after edge n+1+k. This gives a fixed 1-clock latency.
- Word k covers UI k*DATA_WIDTH + j, j = 0..DATA_WIDTH-1.
- Bit j is active (= ~INVERT) iff delay <= k*DATA_WIDTH+j < delay+width. Otherwise bit j = INVERT.
- End computation uses DELAY_WIDTH+1 bits; no wrap.
- At trigger, latch delay and width:
  - coarse = delay >> log2(DATA_WIDTH)
  - fine = delay mod DATA_WIDTH
  - end = delay + width
- FSM states:
  - IDLE:
    - trigger & enable & width != 0 -> DELAY if coarse > 0, else PULSE. busy = 1 from the next cycle.
    - trigger & enable & width == 0 -> stay IDLE. No pulse, busy stays 0, trigger_ignored stays 0.
  - DELAY: decrement the word counter each cycle. Output idle words. Go to PULSE when the word containing UI `delay` is reached.
  - PULSE: emit the per-bit mask for the current word, including partial first and last words. Return to IDLE after the word containing UI end-1.
    - Edges inside one word are legal (e.g. width < DATA_WIDTH).
    - Pulses spanning many words output all-active words in between.
  - busy = 0 in IDLE; busy = 1 in DELAY and PULSE.
- Trigger while busy:
  - Ignored; no change to the latched parameters.
  - trigger_ignored = 1 on the next cycle only.
  - A trigger on the same cycle the FSM returns to IDLE (busy still 1) is also ignored.
- enable low in any state:
  - Next cycle: FSM = IDLE, data_out = idle, busy = 0.
  - Triggers are ignored silently while enable is low; trigger_ignored stays 0.
- delay and width are sampled only at an accepted trigger; later changes have no effect on the current pulse.
- Reset asserted mid-pulse: immediate idle output. After deassertion, wait for a fresh trigger.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- DATA_WIDTH=4, INVERT=0, delay=0, width=4, trigger -> word0 = 4'b1111, word1 = 4'b0000. busy high for 1 cycle.
- delay=5, width=6 -> word0 = 4'b0000, word1 = 4'b1110, word2 = 4'b0111, then 4'b0000. busy high for 3 cycles.
- delay=2, width=1 -> word0 = 4'b0100. delay=0, width=0 -> all words 4'b0000, busy stays 0.
- delay=8, width=100, second trigger at k=3 -> trigger_ignored pulses once. Output unchanged: words 2..26 = 4'b1111, word 27 = 0.
- enable dropped at k=10 of a long pulse -> next word = 4'b0000, busy=0. Reset asserted mid-pulse -> data_out = 0 asynchronously.
- INVERT=1, delay=1, width=2 -> word0 = 4'b1001 after reset idle 4'b1111. Repeat with DATA_WIDTH=8, delay=13, width=3 -> word1 = 8'b1110_0000.
